// File: rtl/ram_mux_pkg.sv
// ram_mux_pkg
// Shared definitions for the N-port single-bank RAM multiplexer:
//   - arbitration mode constants
//   - response-pipeline entry type
//   - lane computation helper for narrow master ports
// No ports (package).
package ram_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Sized for the largest supported configuration: 8 ports, 8 lanes
    // (64-bit RAM with 8-bit masters).
    localparam int IDX_BITS  = 3;
    localparam int LANE_BITS = 3;

    typedef struct packed {
        logic                 valid;
        logic [IDX_BITS-1:0]  idx;
        logic [LANE_BITS-1:0] lane;
    } rsp_entry_t;

    // Which IN_WIDTH-wide lane of the OUT_WIDTH-wide RAM word a byte
    // address falls into. Only the low address bits matter; eight bits
    // cover every supported width combination.
    function automatic logic [LANE_BITS-1:0] lane_of(
        input logic [7:0] addr_lsb,
        input int         out_width,
        input int         in_width
    );
        int byte_off;
        byte_off = int'(addr_lsb) % (out_width / 8);
        return LANE_BITS'(byte_off / (in_width / 8));
    endfunction

endpackage

// File: rtl/ram_mux_nport_rr_arbiter.sv
// rr_arbiter
// Combinational single-grant arbiter, fixed-priority or round-robin.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (clears priority pointer)
//   req      in   per-port request
//   gnt      out  per-port grant, one-hot or zero
//   gnt_idx  out  index of the granted port (0 when nothing is granted)
module rr_arbiter
    import ram_mux_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ARB_MODE  = ARB_FIXED
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS-1:0]         req,
    output logic [NUM_PORTS-1:0]         gnt,
    output logic [$clog2(NUM_PORTS)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    // Highest-priority port in round-robin mode; stays 0 in fixed mode.
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               cand;

    // Scan NUM_PORTS candidates starting at the pointer (or at 0 in fixed
    // mode), wrapping modulo NUM_PORTS; the first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ARB_MODE == ARB_RR) begin
                cand = (int'(ptr_q) + i) % NUM_PORTS;
            end else begin
                cand = i;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    // Winner drops to lowest priority: pointer moves just past it.
    always_comb begin
        ptr_d = ptr_q;
        if (ARB_MODE == ARB_RR && found) begin
            ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_mux_nport.sv
// ram_mux_nport
// N-port arbiter/multiplexer in front of one single-port SRAM bank.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_i/gnt_o/rvalid_o  per-port request, grant (same cycle), response
//   addr_i/we_i/be_i/wdata_i  per-port request payload (IN_WIDTH wide)
//   rdata_o               per-port read data, valid with rvalid_o
//   ram_en_o/ram_addr_o/ram_we_o/ram_be_o/ram_wdata_o  RAM request side
//   ram_rdata_i           RAM read data, RAM_LATENCY cycles after ram_en_o
module ram_mux_nport
    import ram_mux_pkg::*;
#(
    parameter int NUM_PORTS   = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int OUT_WIDTH   = 32,
    parameter int IN_WIDTH    = 32,
    parameter int ARB_MODE    = ARB_FIXED,
    parameter int RAM_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_i,
    output logic [NUM_PORTS-1:0]             gnt_o,
    output logic [NUM_PORTS-1:0]             rvalid_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*IN_WIDTH/8-1:0]  be_i,
    input  logic [NUM_PORTS*IN_WIDTH-1:0]    wdata_i,
    output logic [NUM_PORTS*IN_WIDTH-1:0]    rdata_o,
    output logic                             ram_en_o,
    output logic [ADDR_WIDTH-1:0]            ram_addr_o,
    output logic                             ram_we_o,
    output logic [OUT_WIDTH/8-1:0]           ram_be_o,
    output logic [OUT_WIDTH-1:0]             ram_wdata_o,
    input  logic [OUT_WIDTH-1:0]             ram_rdata_i
);

    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int LANES  = OUT_WIDTH / IN_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IN_BE  = IN_WIDTH / 8;
    localparam int OUT_BE = OUT_WIDTH / 8;

    logic [IDX_W-1:0] gnt_idx;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_i),
        .gnt     (gnt_o),
        .gnt_idx (gnt_idx)
    );

    // ---------------- request mux ----------------
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [IN_BE-1:0]      be_arr    [NUM_PORTS];
    logic [IN_WIDTH-1:0]   wdata_arr [NUM_PORTS];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign be_arr[gi]    = be_i[gi*IN_BE +: IN_BE];
            assign wdata_arr[gi] = wdata_i[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    // gnt_idx is 0 with no request, so port 0 drives the idle bus.
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [IN_BE-1:0]      sel_be;
    logic [IN_WIDTH-1:0]   sel_wdata;
    logic [LANE_BITS-1:0]  sel_lane;

    assign sel_addr  = addr_arr[gnt_idx];
    assign sel_be    = be_arr[gnt_idx];
    assign sel_wdata = wdata_arr[gnt_idx];
    assign sel_lane  = lane_of(sel_addr[7:0], OUT_WIDTH, IN_WIDTH);

    assign ram_en_o    = |req_i;
    assign ram_addr_o  = sel_addr;
    assign ram_we_o    = we_i[gnt_idx];
    // Every lane carries the same data; byte enables pick the real one.
    assign ram_wdata_o = {LANES{sel_wdata}};

    generate
        if (LANES > 1) begin : g_narrow_be
            assign ram_be_o = OUT_BE'(sel_be) << (int'(sel_lane) * IN_BE);
        end else begin : g_pass_be
            assign ram_be_o = sel_be;
        end
    endgenerate

    // ---------------- response pipeline ----------------
    rsp_entry_t pipe_d [RAM_LATENCY];
    rsp_entry_t pipe_q [RAM_LATENCY];
    rsp_entry_t rsp_last;

    always_comb begin
        pipe_d[0].valid = |gnt_o;
        pipe_d[0].idx   = IDX_BITS'(gnt_idx);
        pipe_d[0].lane  = sel_lane;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Only the valid bits are reset; index/lane are don't-care when invalid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RAM_LATENCY; i++) begin
            pipe_q[i].idx  <= pipe_d[i].idx;
            pipe_q[i].lane <= pipe_d[i].lane;
            if (!rst_n) begin
                pipe_q[i].valid <= 1'b0;
            end else begin
                pipe_q[i].valid <= pipe_d[i].valid;
            end
        end
    end

    assign rsp_last = pipe_q[RAM_LATENCY-1];

    logic [IN_WIDTH-1:0] rd_lane [LANES];
    logic [IN_WIDTH-1:0] rd_sel;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rvalid
            assign rvalid_o[gi] = rsp_last.valid && (rsp_last.idx == IDX_BITS'(gi));
        end
        for (genvar gi = 0; gi < LANES; gi++) begin : g_rd_lane
            assign rd_lane[gi] = ram_rdata_i[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    // Read data goes to every port; only the one with rvalid_o cares.
    assign rd_sel  = rd_lane[LANE_W'(rsp_last.lane)];
    assign rdata_o = {NUM_PORTS{rd_sel}};

endmodule

// File: tb/tb_ram_mux_nport.sv
// Testbench for ram_mux_nport. Two instances share one set of requests:
//   dut_a: round-robin, 8-bit ports on a 32-bit RAM, RAM_LATENCY=2
//   dut_b: fixed priority, 32-bit pass-through ports, RAM_LATENCY=1
module tb_ram_mux_nport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] addr  [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic [31:0] ram_rdata;

    logic [95:0] addr_p;
    logic [2:0]  be_a_p;
    logic [23:0] wd_a_p;
    logic [11:0] be_b_p;
    logic [95:0] wd_b_p;

    always_comb begin
        addr_p = '0; be_a_p = '0; wd_a_p = '0; be_b_p = '0; wd_b_p = '0;
        for (int p = 0; p < 3; p++) begin
            addr_p[p*32 +: 32] = addr[p];
            be_a_p[p]          = be[p][0];
            wd_a_p[p*8 +: 8]   = wdata[p][7:0];
            be_b_p[p*4 +: 4]   = be[p];
            wd_b_p[p*32 +: 32] = wdata[p];
        end
    end

    logic [2:0]  gnt_a, rv_a, gnt_b, rv_b;
    logic [23:0] rdata_a;
    logic [95:0] rdata_b;
    logic        ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [31:0] ram_addr_a, ram_wdata_a, ram_addr_b, ram_wdata_b;
    logic [3:0]  ram_be_a, ram_be_b;

    ram_mux_nport #(
        .NUM_PORTS(3), .ADDR_WIDTH(32), .OUT_WIDTH(32), .IN_WIDTH(8),
        .ARB_MODE(1), .RAM_LATENCY(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt_a), .rvalid_o(rv_a),
        .addr_i(addr_p), .we_i(we), .be_i(be_a_p), .wdata_i(wd_a_p),
        .rdata_o(rdata_a), .ram_en_o(ram_en_a), .ram_addr_o(ram_addr_a),
        .ram_we_o(ram_we_a), .ram_be_o(ram_be_a), .ram_wdata_o(ram_wdata_a),
        .ram_rdata_i(ram_rdata)
    );

    ram_mux_nport #(
        .NUM_PORTS(3), .ADDR_WIDTH(32), .OUT_WIDTH(32), .IN_WIDTH(32),
        .ARB_MODE(0), .RAM_LATENCY(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt_b), .rvalid_o(rv_b),
        .addr_i(addr_p), .we_i(we), .be_i(be_b_p), .wdata_i(wd_b_p),
        .rdata_o(rdata_b), .ram_en_o(ram_en_b), .ram_addr_o(ram_addr_b),
        .ram_we_o(ram_we_b), .ram_be_o(ram_be_b), .ram_wdata_o(ram_wdata_b),
        .ram_rdata_i(ram_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", nm, cyc, act, req_v);
        end
    endtask

    // ---------------- reference model ----------------
    // Outstanding responses: due cycle, port, lane.
    typedef struct { int due; int port; int lane; } rsp_t;
    rsp_t qa[$];
    rsp_t qb[$];
    int   ptr_m = 0;

    // Called at the falling edge: checks this cycle, then books the grant.
    task automatic model_check();
        int ga, gb, sa, sb, lane;
        logic [2:0] eva, evb;
        ga = -1; gb = -1;
        for (int i = 0; i < 3; i++) begin
            if (ga < 0 && req[(ptr_m + i) % 3]) ga = (ptr_m + i) % 3;
            if (gb < 0 && req[i]) gb = i;
        end
        sa = (ga < 0) ? 0 : ga;
        sb = (gb < 0) ? 0 : gb;
        lane = int'(addr[sa][1:0]);

        chk("ptr_a",       32'(dut_a.u_arb.ptr_q), 32'(ptr_m));
        chk("gnt_a",       32'(gnt_a), (ga < 0) ? 32'd0 : 32'(1 << ga));
        chk("gnt_b",       32'(gnt_b), (gb < 0) ? 32'd0 : 32'(1 << gb));
        chk("ram_en_a",    32'(ram_en_a), 32'(|req));
        chk("ram_en_b",    32'(ram_en_b), 32'(|req));
        chk("ram_addr_a",  ram_addr_a, addr[sa]);
        chk("ram_addr_b",  ram_addr_b, addr[sb]);
        chk("ram_we_a",    32'(ram_we_a), 32'(we[sa]));
        chk("ram_we_b",    32'(ram_we_b), 32'(we[sb]));
        chk("ram_be_a",    32'(ram_be_a), 32'(be[sa][0]) << lane);
        chk("ram_be_b",    32'(ram_be_b), 32'(be[sb]));
        chk("ram_wdata_a", ram_wdata_a, {4{wdata[sa][7:0]}});
        chk("ram_wdata_b", ram_wdata_b, wdata[sb]);

        eva = '0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            eva = 3'(1 << qa[0].port);
            chk("rdata_a", 32'(rdata_a[qa[0].port*8 +: 8]), 32'(ram_rdata[qa[0].lane*8 +: 8]));
            void'(qa.pop_front());
        end
        chk("rvalid_a", 32'(rv_a), 32'(eva));

        evb = '0;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            evb = 3'(1 << qb[0].port);
            chk("rdata_b", rdata_b[qb[0].port*32 +: 32], ram_rdata);
            void'(qb.pop_front());
        end
        chk("rvalid_b", 32'(rv_b), 32'(evb));

        if (!rst_n) begin
            ptr_m = 0;
            qa.delete();
            qb.delete();
        end else begin
            if (ga >= 0) begin
                qa.push_back('{cyc + 2, ga, lane});
                ptr_m = (ga + 1) % 3;
            end
            if (gb >= 0) qb.push_back('{cyc + 1, gb, 0});
        end
    endtask

    task automatic cycle_end();
        model_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst_n;
        logic [2:0] req;
        logic [2:0] gnt_a;
        int         ptr_a;
        logic [2:0] rv_a;
        logic [2:0] gnt_b;
        logic [2:0] rv_b;
    } vec_t;
    vec_t tbl [18];

    initial begin
        // rst_n, req, gnt_a, ptr_a, rvalid_a, gnt_b, rvalid_b
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 0, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{1'b1, 3'b111, 3'b001, 0, 3'b000, 3'b001, 3'b000};
        tbl[2]  = '{1'b1, 3'b111, 3'b010, 1, 3'b000, 3'b001, 3'b001};
        tbl[3]  = '{1'b1, 3'b111, 3'b100, 2, 3'b001, 3'b001, 3'b001};
        tbl[4]  = '{1'b1, 3'b111, 3'b001, 0, 3'b010, 3'b001, 3'b001};
        tbl[5]  = '{1'b1, 3'b111, 3'b010, 1, 3'b100, 3'b001, 3'b001};
        tbl[6]  = '{1'b1, 3'b111, 3'b100, 2, 3'b001, 3'b001, 3'b001};
        tbl[7]  = '{1'b1, 3'b110, 3'b010, 0, 3'b010, 3'b010, 3'b001};
        tbl[8]  = '{1'b1, 3'b110, 3'b100, 2, 3'b100, 3'b010, 3'b010};
        tbl[9]  = '{1'b1, 3'b110, 3'b010, 0, 3'b010, 3'b010, 3'b010};
        tbl[10] = '{1'b1, 3'b000, 3'b000, 2, 3'b100, 3'b000, 3'b010};
        tbl[11] = '{1'b1, 3'b000, 3'b000, 2, 3'b010, 3'b000, 3'b000};
        tbl[12] = '{1'b1, 3'b000, 3'b000, 2, 3'b000, 3'b000, 3'b000};
        tbl[13] = '{1'b1, 3'b010, 3'b010, 2, 3'b000, 3'b010, 3'b000};
        tbl[14] = '{1'b0, 3'b000, 3'b000, 2, 3'b000, 3'b000, 3'b010};
        tbl[15] = '{1'b1, 3'b110, 3'b010, 0, 3'b000, 3'b010, 3'b000};
        tbl[16] = '{1'b1, 3'b000, 3'b000, 2, 3'b000, 3'b000, 3'b010};
        tbl[17] = '{1'b1, 3'b000, 3'b000, 2, 3'b010, 3'b000, 3'b000};

        rst_n = 1'b0; req = '0; we = '0; ram_rdata = '0;
        for (int p = 0; p < 3; p++) begin
            addr[p] = '0; be[p] = '0; wdata[p] = '0;
        end
        @(posedge clk);
        #1;
        // One checked reset cycle: rvalid must already be clear.
        @(negedge clk);
        cycle_end();

        for (int v = 0; v < 18; v++) begin
            rst_n = tbl[v].rst_n;
            req   = tbl[v].req;
            ram_rdata = $urandom;
            @(negedge clk);
            chk("tbl_gnt_a",    32'(gnt_a), 32'(tbl[v].gnt_a));
            chk("tbl_ptr_a",    32'(dut_a.u_arb.ptr_q), 32'(tbl[v].ptr_a));
            chk("tbl_rvalid_a", 32'(rv_a), 32'(tbl[v].rv_a));
            chk("tbl_gnt_b",    32'(gnt_b), 32'(tbl[v].gnt_b));
            chk("tbl_rvalid_b", 32'(rv_b), 32'(tbl[v].rv_b));
            cycle_end();
        end

        // Narrow-port write, then latency-2 reads on ports 2 and 0.
        rst_n = 1'b1;
        req = 3'b001; we = 3'b001; addr[0] = 32'h1003; be[0] = 4'b0001; wdata[0] = 32'h0000_00A5;
        @(negedge clk);
        chk("lane_be",    32'(ram_be_a), 32'h8);
        chk("lane_wdata", ram_wdata_a, 32'hA5A5_A5A5);
        cycle_end();

        req = 3'b100; we = 3'b000; addr[2] = 32'h2001;
        @(negedge clk);
        chk("rd2_gnt",  32'(gnt_a), 32'b100);
        chk("rd2_addr", ram_addr_a, 32'h2001);
        cycle_end();

        req = 3'b001; ram_rdata = 32'h1122_3344;
        @(negedge clk);
        chk("wr_rvalid", 32'(rv_a), 32'b001);
        chk("wr_rdata",  32'(rdata_a[7:0]), 32'h11);
        cycle_end();

        req = 3'b000; ram_rdata = 32'h5566_7788;
        @(negedge clk);
        chk("rd2_rvalid", 32'(rv_a), 32'b100);
        chk("rd2_rdata",  32'(rdata_a[23:16]), 32'h77);
        cycle_end();

        ram_rdata = 32'h1122_3344;
        @(negedge clk);
        chk("rd0_rvalid", 32'(rv_a), 32'b001);
        chk("rd0_rdata",  32'(rdata_a[7:0]), 32'h11);
        cycle_end();

        ram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("idle_rvalid", 32'(rv_a), 32'b000);
        cycle_end();

        // Randomised traffic with occasional reset, checked by the model.
        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            req   = 3'($urandom);
            we    = 3'($urandom);
            for (int p = 0; p < 3; p++) begin
                addr[p]  = $urandom;
                be[p]    = 4'($urandom);
                wdata[p] = $urandom;
            end
            ram_rdata = $urandom;
            @(negedge clk);
            cycle_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_mux_nport.md
Name: ram_mux_nport

Overview:
- Parametrised N-port arbiter/multiplexer in front of a single-port SRAM bank; successor to the two-port data-RAM mux.
- Adds a configurable port count, selectable arbitration (fixed-priority or round-robin), configurable RAM read latency, and narrow-port lane adaptation.
- Sits between core/debug/AXI-bridge master ports and one ram bank.

Parameters:
NUM_PORTS, 3, number of master ports (2..8)
ADDR_WIDTH, 32, byte address width
OUT_WIDTH, 32, RAM data width (32 or 64)
IN_WIDTH, 32, width of every master port (8..OUT_WIDTH, power of 2)
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
RAM_LATENCY, 1, cycles from ram_en_o to valid ram_rdata_i (1..3)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
req_i  in  NUM_PORTS  per-port request
gnt_o  out  NUM_PORTS  per-port grant, one-hot or zero
rvalid_o  out  NUM_PORTS  per-port response valid
addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port byte address
we_i  in  NUM_PORTS  per-port write enable
be_i  in  NUM_PORTS*IN_WIDTH/8  per-port byte enables
wdata_i  in  NUM_PORTS*IN_WIDTH  per-port write data
rdata_o  out  NUM_PORTS*IN_WIDTH  per-port read data, valid with rvalid_o
ram_en_o  out  1  RAM access enable
ram_addr_o  out  ADDR_WIDTH  RAM address (granted port, unmodified)
ram_we_o  out  1  RAM write enable
ram_be_o  out  OUT_WIDTH/8  RAM byte enables (lane-shifted)
ram_wdata_o  out  OUT_WIDTH  RAM write data (replicated)
ram_rdata_i  in  OUT_WIDTH  RAM read data

Behaviour:
- Grant is combinational, in the same cycle as the request. At most one gnt_o bit is set. ram_en_o = |req_i. RAM outputs come from the granted port; when there is no request they are driven by port 0 with ram_en_o=0.
- ARB_MODE 0: the lowest-index requester wins. No fairness.
- ARB_MODE 1: a priority pointer ptr_q (clog2(NUM_PORTS) bits) marks the highest-priority port. The search starts at ptr_q and wraps modulo NUM_PORTS. On any grant to port k, ptr_q <= (k+1) mod NUM_PORTS, with wrap from NUM_PORTS-1 to 0. With no grant, ptr_q holds.
- Lane adaptation when IN_WIDTH<OUT_WIDTH:
  - lane = addr[clog2(OUT_WIDTH/8)-1 : clog2(IN_WIDTH/8)].
  - ram_be_o holds the port's be in that lane and zeros elsewhere.
  - ram_wdata_o = wdata replicated OUT_WIDTH/IN_WIDTH times.
  - When IN_WIDTH==OUT_WIDTH, be, wdata and rdata pass through unchanged.
- Response pipeline: a RAM_LATENCY-deep shift register of {valid, port index, lane}.
  - Stage 0 is loaded every cycle with {|gnt_o, granted index, lane}.
  - At the final stage, rvalid_o[idx] = valid. Every other rvalid_o bit is 0.
  - rvalid is issued for writes as well as reads, exactly RAM_LATENCY cycles after the grant.
  - rdata_o for port p = the lane slice of ram_rdata_i selected by the final-stage lane. The value is only meaningful while rvalid_o[p]=1 and is driven for all ports every cycle.
- Back-to-back grants give one response per cycle, with no bubbles and full throughput.
- Simultaneous requests: exactly one grant. Losers keep req_i asserted and hold their address, be, wdata and we stable until granted.
- Reset (synchronous, rst_n=0 at a clk edge):
  - ptr_q=0, all pipeline valids=0, rvalid_o=0.
  - In-flight responses are dropped. Masters must discard outstanding transactions.
  - gnt_o and ram_* remain combinational and follow req_i even during reset; ram_en_o is not gated.
- Lane and index pipeline registers need no reset; only the valid bits do.

Decomposition:
- Package ram_mux_pkg:
  - ARB_FIXED=0 and ARB_RR=1 constants.
  - A function for lane computation from address and widths.
  - Typedef for the response-pipeline entry (valid, idx, lane).
- One sub-module, rr_arbiter:
  - Parameters NUM_PORTS and ARB_MODE.
  - I/O: req, gnt, gnt_idx, owns ptr_q.
  - The top level holds the lane adaptation and the response pipeline.

Test Plan:
- Fixed priority, NUM_PORTS=3, req_i=3'b110 for 3 cycles -> gnt_o=3'b010 every cycle. rvalid_o[1] appears 1 cycle after each grant (RAM_LATENCY=1). Port 2 is never granted.
- Round-robin, req_i=3'b111 held for 6 cycles after reset -> grant order 0,1,2,0,1,2. ptr_q reads 1,2,0,1,2,0.
- Narrow port (IN_WIDTH=8, OUT_WIDTH=32), write addr=0x1003, be=1, wdata=0xA5 -> ram_be_o=4'b1000, ram_wdata_o=0xA5A5A5A5. A read with ram_rdata_i=0x11223344 then gives rdata_o=0x11.
- RAM_LATENCY=2, reads granted to port 0 in cycle 0 and port 2 in cycle 1 -> rvalid_o[0] in cycle 2 and rvalid_o[2] in cycle 3, each carrying the correct lane data.
- rst_n=0 one cycle after a grant with RAM_LATENCY=2 -> no rvalid_o pulse follows. After release, ptr_q=0 and the first round-robin grant goes to the lowest requester from 0.
- Idle, req_i=0 -> ram_en_o=0, gnt_o=0, and rvalid_o=0 on the next cycle.
